slave_port_arbiter: RTL

- Shares one crossbar slave port among MASTER_NUM masters using a req/ack command handshake.
- Records the master ID of every accepted read in an in-order FIFO, so read responses and read data route back to the issuing master.
- Sits in port_handle, between the master-side request muxing and the slave port.
- Replaces counter-based response steering with exact ordered tracking.

---
 rtl/slave_port_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/slave_port_arbiter.sv
// Shares one slave port among MASTER_NUM masters; read IDs are kept in an in-order FIFO to steer responses back.
// Two-cycle request-to-ack; reads stall while the ID FIFO is full. ARB_FIXED_PRIO_EN selects lowest-index-first arbitration.
module slave_port_arbiter #(
  parameter int MASTER_NUM  = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int OUTST_DEPTH = 8
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [MASTER_NUM-1:0]            m_req,
  input  logic [MASTER_NUM-1:0]            m_cmd,
  input  logic [MASTER_NUM*ADDR_WIDTH-1:0] m_addr,
  input  logic [MASTER_NUM*DATA_WIDTH-1:0] m_wdata,
  output logic [MASTER_NUM-1:0]            m_ack,
  output logic [MASTER_NUM-1:0]            m_resp,
  output logic [DATA_WIDTH-1:0]            m_rdata,
  output logic                             s_req,
  output logic                             s_cmd,
  output logic [ADDR_WIDTH-1:0]            s_addr,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  input  logic                             s_ack,
  input  logic                             s_resp,
  input  logic [DATA_WIDTH-1:0]            s_rdata,
  output logic                             busy,
  output logic [$clog2(OUTST_DEPTH):0]     outst_cnt
);

  localparam int IW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
  localparam int PW = $clog2(OUTST_DEPTH);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state, state_nxt;
  logic [MASTER_NUM-1:0] grant, grant_nxt;
  logic [IW-1:0]         gidx, pick_idx;
  logic                  pick_vld;
  logic [IW-1:0]         fifo_mem [OUTST_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           cnt;
  logic                  full, empty, push, pop, xfer, g_req, g_rd;
`ifndef ARB_FIXED_PRIO_EN
  logic [IW-1:0]         rr_ptr;
  int                    j;
`endif

  assign full  = (cnt == (PW+1)'(OUTST_DEPTH));
  assign empty = (cnt == '0);
  assign pop   = s_resp & ~empty;
  assign g_req = m_req[gidx];
  assign g_rd  = ~m_cmd[gidx];
  assign xfer  = s_req & s_ack;
  assign push  = xfer & g_rd;

  assign m_rdata   = s_rdata;
  assign busy      = (state == GRANT);
  assign outst_cnt = cnt;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < MASTER_NUM; i++)
      if (grant[i]) gidx = IW'(i);
  end

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = MASTER_NUM - 1; i >= 0; i--) begin
      if (m_req[i]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(i);
      end
    end
`else
    j = 0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= MASTER_NUM) j = j - MASTER_NUM;
      if (!pick_vld && m_req[j[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = j[IW-1:0];
      end
    end
`endif
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
      grant <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  // A full-blocked read keeps its grant; only a transfer or a dropped request releases it.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = GRANT;
          grant_nxt = MASTER_NUM'(1) << pick_idx;
        end
      end
      GRANT: begin
        if (xfer || !g_req) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // A response popping the full FIFO frees a slot in the same cycle, so a blocked read may push alongside it.
  always_comb begin
    s_req   = 1'b0;
    s_cmd   = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    m_ack   = '0;
    m_resp  = '0;
    if (state == GRANT) begin
      s_req   = g_req & ~(g_rd & full & ~pop);
      s_cmd   = m_cmd[gidx];
      s_addr  = m_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
      s_wdata = m_wdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
      m_ack[gidx] = xfer;
    end
    m_resp[fifo_mem[rd_ptr]] = pop;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr <= '0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
`ifndef ARB_FIXED_PRIO_EN
      if (xfer) rr_ptr <= (int'(gidx) == MASTER_NUM - 1) ? '0 : gidx + 1'b1;
`endif
    end
  end

  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wr_ptr] <= gidx;
  end

endmodule
